// File: rtl/can_pkg.sv
// Shared constants, state encoding and helpers for the CAN base-frame transmitter.
package can_pkg;
    localparam logic [14:0] CRC15_POLY    = 15'h4599;
    localparam int          ID_W          = 11;
    localparam int          DLC_W         = 4;
    localparam int          MAX_BYTES     = 8;
    localparam int          STUFF_RUN     = 5;
    localparam int          HDR_BITS      = 19;  // SOF + ID + RTR + IDE + r0 + DLC
    localparam int          CRC_BITS      = 15;
    localparam int          TRL_FIXED_LEN = 3;   // CRC delimiter, ACK slot, ACK delimiter
    localparam int          EOF_LEN_DEF   = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_HDR,
        ST_RD_DATA,
        ST_ARB,
        ST_STUFFED,
        ST_TRAILER,
        ST_DONE
    } state_t;

    function automatic logic [3:0] payload_bytes(input logic [3:0] dlc);
        return (dlc > 4'd8) ? 4'd8 : dlc;
    endfunction
endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 register, one message bit per enabled cycle.
module can_crc15
    import can_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        bit_en,
    input  logic        bit_in,
    output logic [14:0] crc
);
    logic [14:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (bit_en) begin
            crc_d = {crc_q[13:0], 1'b0} ^ ((bit_in ^ crc_q[14]) ? CRC15_POLY : 15'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) crc_q <= '0;
        else       crc_q <= crc_d;
    end

    assign crc = crc_q;
endmodule

// File: rtl/can_frame_tx.sv
// Fetches a frame descriptor over Avalon-MM and serializes a CAN 2.0A data frame
// with CRC-15, bit stuffing and a recessive trailer, one bit per bit_tick.
module can_frame_tx
    import can_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int EOF_LEN = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    input  logic              waitrequest,
    input  logic [31:0]       readdata,
    input  logic              bit_tick,
    output logic              tx,
    output logic              busy,
    output logic              finish,
    output logic [31:0]       return_val
);
    localparam int         SH_W     = HDR_BITS + 8 * MAX_BYTES;
    localparam logic [4:0] TRL_LAST = 5'(TRL_FIXED_LEN + EOF_LEN - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic [6:0]        len_q, len_d;
    logic [6:0]        pos_q, pos_d;
    logic [2:0]        run_q, run_d;
    logic              last_q, last_d;
    logic              tx_q, tx_d;
    logic [1:0]        words_q, words_d;
    logic              widx_q, widx_d;
    logic [7:0]        bitcnt_q, bitcnt_d;
    logic [4:0]        trl_q, trl_d;
    logic [31:0]       ret_q, ret_d;

    logic        crc_clear, crc_en, crc_bit;
    logic [14:0] crc;
    logic [15:0] crc_ext;
    logic [3:0]  crc_idx, nbytes;
    logic        stuff_due, in_crc, out_bit;

    can_crc15 u_crc (
        .clk    (clk),
        .reset  (reset),
        .clear  (crc_clear),
        .bit_en (crc_en),
        .bit_in (crc_bit),
        .crc    (crc)
    );

    // The CRC field is read MSB first straight out of the (by then final) CRC register.
    assign crc_ext   = {1'b0, crc};
    assign crc_idx   = 4'(len_q + 7'd14 - pos_q);
    assign nbytes    = payload_bytes(readdata[19:16]);
    assign stuff_due = (run_q == 3'(STUFF_RUN));
    assign in_crc    = (pos_q >= len_q);
    assign out_bit   = stuff_due ? ~last_q : (in_crc ? crc_ext[crc_idx] : sh_q[SH_W-1]);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sh_d      = sh_q;
        len_d     = len_q;
        pos_d     = pos_q;
        run_d     = run_q;
        last_d    = last_q;
        tx_d      = tx_q;
        words_d   = words_q;
        widx_d    = widx_q;
        bitcnt_d  = bitcnt_q;
        trl_d     = trl_q;
        ret_d     = ret_q;
        crc_clear = 1'b0;
        crc_en    = 1'b0;
        crc_bit   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RD_HDR;
                    addr_d    = base_addr;
                    sh_d      = '0;
                    pos_d     = '0;
                    run_d     = '0;
                    last_d    = 1'b1;
                    widx_d    = 1'b0;
                    bitcnt_d  = '0;
                    trl_d     = '0;
                    crc_clear = 1'b1;
                end
            end
            ST_RD_HDR: begin
                if (!waitrequest) begin
                    sh_d[SH_W-1 -: HDR_BITS] = {1'b0, readdata[10:0], 3'b000, readdata[19:16]};
                    len_d   = 7'(HDR_BITS) + {nbytes, 3'b000};
                    words_d = 2'((nbytes + 4'd3) >> 2);
                    if (nbytes == 4'd0) begin
                        state_d = ST_ARB;
                    end else begin
                        state_d = ST_RD_DATA;
                        addr_d  = addr_q + 1'b1;
                    end
                end
            end
            ST_RD_DATA: begin
                if (!waitrequest) begin
                    if (!widx_q) sh_d[63:32] = readdata;
                    else         sh_d[31:0]  = readdata;
                    widx_d  = 1'b1;
                    words_d = words_q - 2'd1;
                    if (words_q == 2'd1) state_d = ST_ARB;
                    else                 addr_d  = addr_q + 1'b1;
                end
            end
            // ARB's first tick already carries SOF, so both states share the stuffing path.
            ST_ARB, ST_STUFFED: begin
                if (bit_tick) begin
                    tx_d     = out_bit;
                    last_d   = out_bit;
                    bitcnt_d = bitcnt_q + 8'd1;
                    if (stuff_due || out_bit != last_q) run_d = 3'd1;
                    else                                run_d = run_q + 3'd1;
                    if (!stuff_due) begin
                        pos_d = pos_q + 7'd1;
                        if (!in_crc) begin
                            sh_d    = sh_q << 1;
                            crc_en  = 1'b1;
                            crc_bit = out_bit;
                        end
                    end
                    if (pos_d == len_q + 7'(CRC_BITS) && run_d != 3'(STUFF_RUN))
                        state_d = ST_TRAILER;
                    else
                        state_d = ST_STUFFED;
                end
            end
            ST_TRAILER: begin
                if (bit_tick) begin
                    tx_d     = 1'b1;
                    bitcnt_d = bitcnt_q + 8'd1;
                    trl_d    = trl_q + 5'd1;
                    if (trl_q == TRL_LAST) begin
                        state_d = ST_DONE;
                        ret_d   = 32'(bitcnt_q) + 32'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state is reset; the descriptor shift register and length are data only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            pos_q    <= '0;
            run_q    <= '0;
            last_q   <= 1'b1;
            tx_q     <= 1'b1;
            words_q  <= '0;
            widx_q   <= 1'b0;
            bitcnt_q <= '0;
            trl_q    <= '0;
            ret_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            pos_q    <= pos_d;
            run_q    <= run_d;
            last_q   <= last_d;
            tx_q     <= tx_d;
            words_q  <= words_d;
            widx_q   <= widx_d;
            bitcnt_q <= bitcnt_d;
            trl_q    <= trl_d;
            ret_q    <= ret_d;
        end
        sh_q  <= sh_d;
        len_q <= len_d;
    end

    assign address    = addr_q;
    assign read       = (state_q == ST_RD_HDR) || (state_q == ST_RD_DATA);
    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE);
    assign finish     = (state_q == ST_DONE);
    assign return_val = ret_q;
endmodule
